// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round/schedule functions and shared types
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef struct packed { word_t a, b, c, d, e, f, g, h; } state_t;
    typedef enum logic [1:0] {S_IDLE, S_ROUNDS, S_FINAL} fsm_t;

    localparam state_t IV = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic state_t state_add(input state_t x, input state_t y);
        return '{x.a + y.a, x.b + y.b, x.c + y.c, x.d + y.d,
                 x.e + y.e, x.f + y.f, x.g + y.g, x.h + y.h};
    endfunction

    // Window holds W[t] in [511:480]; later new words may depend on earlier new words.
    function automatic logic [511:0] sched_next(input logic [511:0] win, input int n);
        word_t ext [0:23];
        for (int k = 0; k < 16; k++) ext[k] = win[511-32*k -: 32];
        for (int k = 16; k < 24; k++) ext[k] = '0;
        for (int j = 0; j < n; j++)
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        for (int k = 0; k < 16; k++) sched_next[511-32*k -: 32] = ext[k+n];
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round
module sha256_round
    import sha256_pkg::*;
(
    input  state_t i_state,
    input  word_t  i_w,
    input  word_t  i_k,
    output state_t o_state
);

    word_t w_t1;
    word_t w_t2;

    assign w_t1 = i_state.h + big_sigma1(i_state.e) + ch(i_state.e, i_state.f, i_state.g) + i_k + i_w;
    assign w_t2 = big_sigma0(i_state.a) + maj(i_state.a, i_state.b, i_state.c);

    assign o_state = '{w_t1 + w_t2, i_state.a, i_state.b, i_state.c,
                       i_state.d + w_t1, i_state.e, i_state.f, i_state.g};

endmodule

// File: rtl/sha256_unrolled_core.sv
// rtl/sha256_unrolled_core.sv - UNROLL-rounds-per-clock SHA-256 compression core; SHA256_CORE_DOUBLE_HASH_EN adds SHA256d mode
module sha256_unrolled_core
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         init,
    input  logic [511:0] block_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest_out
`ifdef SHA256_CORE_DOUBLE_HASH_EN
    ,
    input  logic         dbl
`endif
);

    localparam logic [5:0] LAST_T = 6'(64 - UNROLL);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256_unrolled_core: UNROLL must be 1, 2, 4 or 8");
    end

    fsm_t         r_fsm;
    fsm_t         w_fsm_nxt;
    logic [5:0]   r_t;
    logic [511:0] r_w;
    state_t       r_st;
    state_t       r_h;
    state_t       r_digest;
    logic         r_busy;
    logic         r_done;
    logic         w_load;
    logic         w_step;
    logic         w_finish;
    logic         w_rehash;
    state_t       w_sum;
    state_t       w_rnd_out;
`ifdef SHA256_CORE_DOUBLE_HASH_EN
    logic         r_dbl;
`endif

    for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
        state_t w_in;
        state_t w_out;
        if (i == 0) begin : g_first
            assign w_in = r_st;
        end else begin : g_next
            assign w_in = g_rnd[i-1].w_out;
        end
        sha256_round u_round (
            .i_state (w_in),
            .i_w     (r_w[511-32*i -: 32]),
            .i_k     (K[r_t + 6'(i)]),
            .o_state (w_out)
        );
    end

    assign w_rnd_out  = g_rnd[UNROLL-1].w_out;
    assign w_sum      = state_add(r_h, r_st);
    assign busy       = r_busy;
    assign done       = r_done;
    assign digest_out = r_digest;

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_finish  = 1'b0;
        w_rehash  = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_fsm_nxt = S_ROUNDS;
                end
            end
            S_ROUNDS: begin
                w_step = 1'b1;
                if (r_t == LAST_T) w_fsm_nxt = S_FINAL;
            end
            S_FINAL: begin
`ifdef SHA256_CORE_DOUBLE_HASH_EN
                if (r_dbl) begin
                    w_rehash  = 1'b1;
                    w_fsm_nxt = S_ROUNDS;
                end else begin
                    w_finish  = 1'b1;
                    w_fsm_nxt = S_IDLE;
                end
`else
                w_finish  = 1'b1;
                w_fsm_nxt = S_IDLE;
`endif
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // r_t wraps to 0 on the last step, so a second pass needs no explicit clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fsm    <= S_IDLE;
            r_t      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_digest <= IV;
`ifdef SHA256_CORE_DOUBLE_HASH_EN
            r_dbl    <= 1'b0;
`endif
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_done <= w_finish;
            if (w_load) begin
                r_busy <= 1'b1;
                r_t    <= '0;
            end
            if (w_step) r_t <= r_t + 6'(UNROLL);
            if (w_finish) begin
                r_busy   <= 1'b0;
                r_digest <= w_sum;
            end
`ifdef SHA256_CORE_DOUBLE_HASH_EN
            if (w_load)   r_dbl <= dbl;
            if (w_rehash) r_dbl <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_w  <= block_in;
            r_st <= init ? IV : r_digest;
            r_h  <= init ? IV : r_digest;
        end else if (w_step) begin
            r_w  <= sched_next(r_w, UNROLL);
            r_st <= w_rnd_out;
        end else if (w_rehash) begin
            r_w  <= {w_sum, 32'h80000000, 192'h0, 32'h00000100};
            r_st <= IV;
            r_h  <= IV;
        end
    end

endmodule

// File: tb/tb_sha256_unrolled_core.sv
// tb/tb_sha256_unrolled_core.sv - scoreboard bench for sha256_unrolled_core against a reference SHA-256 model
module tb_sha256_unrolled_core;

    localparam int UNROLL = 4;
    localparam int LAT    = 64 / UNROLL + 1;
    localparam logic [255:0] IV_C = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_L1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_L2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DG_LONG  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         init = 1'b0;
    logic [511:0] block_in = '0;
    logic         busy;
    logic         done;
    logic [255:0] digest_out;
`ifdef SHA256_CORE_DOUBLE_HASH_EN
    logic         dbl = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [255:0] h_model = IV_C;
    logic [255:0] q_dig [$];
    int           q_cyc [$];
    string        q_tag [$];

    sha256_unrolled_core #(.UNROLL(UNROLL)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .init       (init),
        .block_in   (block_in),
        .busy       (busy),
        .done       (done),
        .digest_out (digest_out)
`ifdef SHA256_CORE_DOUBLE_HASH_EN
        ,
        .dbl        (dbl)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-entry message schedule, then 64 rounds.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q_dig.size() == 0) begin
                check("stray_done", 256'(done), 256'(0));
            end else begin
                check({q_tag[0], "_digest"}, digest_out, q_dig[0]);
                check({q_tag[0], "_latency"}, 256'(cyc), 256'(q_cyc[0]));
                check({q_tag[0], "_busy_at_done"}, 256'(busy), 256'(0));
                void'(q_dig.pop_front());
                void'(q_cyc.pop_front());
                void'(q_tag.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 256'(busy), 256'(0));
    endtask

    task automatic issue(input logic [511:0] blk, input bit ini, input bit dbl_en, input string tag,
                         input bit kat_en, input logic [255:0] kat, output int acc);
        logic [255:0] expd;
        wait_idle();
        expd = kat_en ? kat : ref_compress(ini ? IV_C : h_model, blk);
        start    = 1'b1;
        init     = ini;
        block_in = blk;
`ifdef SHA256_CORE_DOUBLE_HASH_EN
        dbl      = dbl_en;
`endif
        acc = cyc + 1;
        q_dig.push_back(expd);
        q_cyc.push_back(acc + (dbl_en ? 2 * LAT : LAT));
        q_tag.push_back(tag);
        h_model = expd;
        @(negedge clk);
        start    = 1'b0;
        init     = 1'($urandom);
        block_in = {16{$urandom}};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1, acc2;
        logic [511:0] blk;
        repeat (3) @(negedge clk);
        check("reset_digest", digest_out, IV_C);
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_done", 256'(done), 256'(0));
        reset_n = 1'b1;
        @(negedge clk);

        issue(BLK_ABC, 1'b1, 1'b0, "abc", 1'b1, DG_ABC, acc1);
        issue(BLK_EMPTY, 1'b1, 1'b0, "empty", 1'b1, DG_EMPTY, acc1);

        issue(BLK_L1, 1'b1, 1'b0, "long_blk1", 1'b0, '0, acc1);
        issue(BLK_L2, 1'b0, 1'b0, "long_blk2", 1'b1, DG_LONG, acc2);
        check("b2b_accept_edge", 256'(acc2), 256'(acc1 + LAT + 1));

        issue(BLK_EMPTY, 1'b1, 1'b0, "ignored_start", 1'b1, DG_EMPTY, acc1);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        init     = 1'b1;
        block_in = BLK_ABC;
        @(negedge clk);
        start    = 1'b0;
        check("busy_during_rounds", 256'(busy), 256'(1));

        issue(BLK_ABC, 1'b1, 1'b0, "aborted", 1'b0, '0, acc1);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        q_dig.delete();
        q_cyc.delete();
        q_tag.delete();
        h_model = IV_C;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_digest", digest_out, IV_C);
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_done", 256'(done), 256'(0));
        repeat (LAT + 4) @(negedge clk);
        issue(BLK_ABC, 1'b1, 1'b0, "abc_after_reset", 1'b1, DG_ABC, acc1);

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 16; k++) blk[511-32*k -: 32] = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(blk, (i == 0) ? 1'b1 : 1'($urandom), 1'b0, $sformatf("rand%0d", i), 1'b0, '0, acc1);
        end

`ifdef SHA256_CORE_DOUBLE_HASH_EN
        issue(BLK_ABC, 1'b1, 1'b1, "abc_dbl", 1'b1,
              256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358, acc1);
`endif

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 256'(q_dig.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
